// File: rtl/sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sub_arbiter
// Purpose  : Round-robin arbiter that shares one external registered
//            subtractor (c = a - b, SUB_LAT cycles) between NUM_REQ
//            requesters. Tracks in-flight ops by requester id and returns
//            each result as a one-cycle, one-hot response pulse.
// Ports    : clk         - clock, all state on rising edge
//            reset       - asynchronous active-low reset
//            enable      - 1 = grants allowed; in-flight ops always complete
//            req_valid   - per-requester request valid
//            req_ready   - per-requester grant (at most one bit set)
//            req_a/req_b - packed operands, requester i at [i*WIDTH +: WIDTH]
//            sub_a/sub_b - operands presented to the subtractor
//            sub_c       - subtractor result, SUB_LAT cycles after operands
//            resp_valid  - one-hot response pulse to the owning requester
//            resp_id     - id of the responding requester
//            resp_data   - result, meaningful while resp_valid != 0
//            resp_borrow - (SUB_ARBITER_BORROW_EN only) a < b at issue
//            busy        - any operation in flight
// Options  : `define SUB_ARBITER_BORROW_EN adds resp_borrow.
// Revision : 1.0 - initial release
// ============================================================================
module sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int SUB_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           sub_a,
  output logic [WIDTH-1:0]           sub_b,
  input  logic [WIDTH-1:0]           sub_c,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_data,
`ifdef SUB_ARBITER_BORROW_EN
  output logic                       resp_borrow,
`endif
  output logic                       busy
);

  localparam int                c_id_w    = $clog2(NUM_REQ);
  localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // Operand unpacking
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_id_w-1:0]               rr_ptr_q,     rr_ptr_d;
  logic [WIDTH-1:0]                op_a_q,       op_a_d;
  logic [WIDTH-1:0]                op_b_q,       op_b_d;
  logic [SUB_LAT-1:0]              tag_vld_q,    tag_vld_d;
  logic [SUB_LAT-1:0][c_id_w-1:0]  tag_id_q,     tag_id_d;
  logic [NUM_REQ-1:0]              resp_valid_q, resp_valid_d;
  logic [c_id_w-1:0]               resp_id_q,    resp_id_d;
  logic [WIDTH-1:0]                resp_data_q,  resp_data_d;
`ifdef SUB_ARBITER_BORROW_EN
  logic [SUB_LAT-1:0]              tag_brw_q,    tag_brw_d;
  logic                            resp_brw_q,   resp_brw_d;
  logic                            issue_brw;
`endif

  // --------------------------------------------------------------------------
  // Round-robin grant
  // --------------------------------------------------------------------------
  logic              grant_vld;
  logic [c_id_w-1:0] grant_id;
  logic [c_id_w-1:0] cand;
  logic              accept;

  // Candidates are scanned from the farthest offset back to rr_ptr so the
  // last hit, which wins, is the nearest valid requester at or after rr_ptr.
  // Reset low forces the grant off independent of the clock.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (reset && enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = c_id_w'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  assign accept    = |(req_valid & req_ready);

  // Operands follow the granted requester; otherwise the last issued pair
  // is held so the subtractor inputs do not toggle while idle.
  assign sub_a = accept ? a_arr[grant_id] : op_a_q;
  assign sub_b = accept ? b_arr[grant_id] : op_b_q;

`ifdef SUB_ARBITER_BORROW_EN
  assign issue_brw = accept && (a_arr[grant_id] < b_arr[grant_id]);
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_id == c_last_id) ? '0 : grant_id + 1'b1;
    end
    op_a_d = sub_a;
    op_b_d = sub_b;
  end

  // Tag pipeline mirrors the subtractor latency: the tag leaving the last
  // stage lines up with the matching result on sub_c.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = accept;
    tag_id_d[0]  = grant_id;
    for (int s = 1; s < SUB_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

`ifdef SUB_ARBITER_BORROW_EN
  always_comb begin
    tag_brw_d    = '0;
    tag_brw_d[0] = issue_brw;
    for (int s = 1; s < SUB_LAT; s++) begin
      tag_brw_d[s] = tag_brw_q[s-1];
    end
  end
`endif

  // Response fields are zeroed between pulses so stale ids/data never linger.
  always_comb begin
    resp_valid_d = '0;
    resp_id_d    = '0;
    resp_data_d  = '0;
    if (tag_vld_q[SUB_LAT-1]) begin
      resp_valid_d = NUM_REQ'(1) << tag_id_q[SUB_LAT-1];
      resp_id_d    = tag_id_q[SUB_LAT-1];
      resp_data_d  = sub_c;
    end
  end

`ifdef SUB_ARBITER_BORROW_EN
  always_comb begin
    resp_brw_d = 1'b0;
    if (tag_vld_q[SUB_LAT-1]) begin
      resp_brw_d = tag_brw_q[SUB_LAT-1];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

`ifdef SUB_ARBITER_BORROW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_brw_q  <= '0;
      resp_brw_q <= 1'b0;
    end else begin
      tag_brw_q  <= tag_brw_d;
      resp_brw_q <= resp_brw_d;
    end
  end

  assign resp_borrow = resp_brw_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (|tag_vld_q) | (|resp_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_arbiter
// Purpose  : Directed, table-driven bench for sub_arbiter. One instance at
//            SUB_LAT=1 runs the vector table plus a mid-operation reset
//            sequence; a second instance at SUB_LAT=3 checks deep-pipeline
//            response timing. Each instance gets a behavioural subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  // Fixed operand set: r0 99, r1 0 (equal), r2 7, r3 wraps (borrow)
  localparam logic [W-1:0] A0 = 32'd100, B0 = 32'd1;
  localparam logic [W-1:0] A1 = 32'd5,   B1 = 32'd5;
  localparam logic [W-1:0] A2 = 32'd10,  B2 = 32'd3;
  localparam logic [W-1:0] A3 = 32'd3,   B3 = 32'd5;
  localparam logic [W-1:0] D0 = 32'd99;
  localparam logic [W-1:0] D1 = 32'd0;
  localparam logic [W-1:0] D2 = 32'd7;
  localparam logic [W-1:0] D3 = 32'hFFFF_FFFE;

  logic clk;
  logic reset;
  logic enable;

  logic [N*W-1:0] req_a, req_b;
  assign req_a = {A3, A2, A1, A0};
  assign req_b = {B3, B2, B1, B0};

  // SUB_LAT = 1 instance
  logic [N-1:0] req_valid1, req_ready1, resp_valid1;
  logic [W-1:0] sub_a1, sub_b1, sub_c1, resp_data1;
  logic [1:0]   resp_id1;
  logic         busy1;
`ifdef SUB_ARBITER_BORROW_EN
  logic         resp_borrow1;
`endif

  // SUB_LAT = 3 instance
  logic [N-1:0] req_valid3, req_ready3, resp_valid3;
  logic [W-1:0] sub_a3, sub_b3, sub_c3, resp_data3;
  logic [1:0]   resp_id3;
  logic         busy3;
`ifdef SUB_ARBITER_BORROW_EN
  logic         resp_borrow3;
`endif

  sub_arbiter #(.NUM_REQ(N), .WIDTH(W), .SUB_LAT(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_a      (req_a),
    .req_b      (req_b),
    .sub_a      (sub_a1),
    .sub_b      (sub_b1),
    .sub_c      (sub_c1),
    .resp_valid (resp_valid1),
    .resp_id    (resp_id1),
    .resp_data  (resp_data1),
`ifdef SUB_ARBITER_BORROW_EN
    .resp_borrow(resp_borrow1),
`endif
    .busy       (busy1)
  );

  sub_arbiter #(.NUM_REQ(N), .WIDTH(W), .SUB_LAT(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid3),
    .req_ready  (req_ready3),
    .req_a      (req_a),
    .req_b      (req_b),
    .sub_a      (sub_a3),
    .sub_b      (sub_b3),
    .sub_c      (sub_c3),
    .resp_valid (resp_valid3),
    .resp_id    (resp_id3),
    .resp_data  (resp_data3),
`ifdef SUB_ARBITER_BORROW_EN
    .resp_borrow(resp_borrow3),
`endif
    .busy       (busy3)
  );

  // Behavioural subtractors
  logic [W-1:0] p1, p2, p3;
  always @(posedge clk) sub_c1 <= sub_a1 - sub_b1;
  always @(posedge clk) begin
    p1 <= sub_a3 - sub_b3;
    p2 <= p1;
    p3 <= p2;
  end
  assign sub_c3 = p3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   valid;
    logic         en;
    logic [3:0]   exp_ready;
    logic [3:0]   exp_rv;
    logic [1:0]   exp_id;
    logic [W-1:0] exp_data;
    logic         exp_busy;
    logic         exp_brw;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  // Expected response sequence for the SUB_LAT=3 instance, cycles c0..c7
  logic [3:0]   exp_rv3   [8];
  logic [1:0]   exp_id3   [8];
  logic [W-1:0] exp_data3 [8];

  initial begin
    // Each row is one clock cycle; accepted in cycle n -> response in n+2.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, '0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd2, D2, 1'b1, 1'b0};
    tbl[3]  = '{4'b1000, 1'b1, 4'b1000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 2'd0, '0, 1'b1, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b1000, 2'd3, D3, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 2'd0, D0, 1'b1, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 4'b0010, 2'd1, D1, 1'b1, 1'b0};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 4'b0100, 2'd2, D2, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 4'b1000, 2'd3, D3, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 2'd0, D0, 1'b1, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[12] = '{4'b1111, 1'b1, 4'b0010, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[13] = '{4'b1111, 1'b1, 4'b0100, 4'b0000, 2'd0, '0, 1'b1, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 4'b0000, 4'b0010, 2'd1, D1, 1'b1, 1'b0};
    tbl[15] = '{4'b1111, 1'b0, 4'b0000, 4'b0100, 2'd2, D2, 1'b1, 1'b0};
    tbl[16] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[17] = '{4'b1111, 1'b1, 4'b1000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[18] = '{4'b0101, 1'b1, 4'b0001, 4'b0000, 2'd0, '0, 1'b1, 1'b0};
    tbl[19] = '{4'b0101, 1'b1, 4'b0100, 4'b1000, 2'd3, D3, 1'b1, 1'b1};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 2'd0, D0, 1'b1, 1'b0};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd2, D2, 1'b1, 1'b0};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    // valid raised then dropped while disabled: nothing issued
    tbl[23] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[24] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};
    tbl[25] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, '0, 1'b0, 1'b0};

    // SUB_LAT=3: accepts in c0,c1,c2 -> responses in c4,c5,c6
    for (int k = 0; k < 8; k++) begin
      exp_rv3[k]   = 4'b0000;
      exp_id3[k]   = 2'd0;
      exp_data3[k] = '0;
    end
    exp_rv3[4] = 4'b0001; exp_id3[4] = 2'd0; exp_data3[4] = D0;
    exp_rv3[5] = 4'b0010; exp_id3[5] = 2'd1; exp_data3[5] = D1;
    exp_rv3[6] = 4'b0100; exp_id3[6] = 2'd2; exp_data3[6] = D2;

    // ---------------- reset state ----------------
    reset      = 1'b0;
    enable     = 1'b1;
    req_valid1 = 4'b1111;
    req_valid3 = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    chk("reset ready",      64'(req_ready1),  64'(4'b0000));
    chk("reset resp_valid", 64'(resp_valid1), 64'(4'b0000));
    chk("reset resp_id",    64'(resp_id1),    64'(2'd0));
    chk("reset resp_data",  64'(resp_data1),  64'(0));
    chk("reset busy",       64'(busy1),       64'(1'b0));
`ifdef SUB_ARBITER_BORROW_EN
    chk("reset borrow",     64'(resp_borrow1), 64'(1'b0));
`endif
    @(posedge clk);
    #1;
    reset      = 1'b1;
    req_valid1 = 4'b0000;

    // ---------------- table vectors ----------------
    for (int i = 0; i < NV; i++) begin
      req_valid1 = tbl[i].valid;
      enable     = tbl[i].en;
      #2;
      chk($sformatf("v%0d ready", i),      64'(req_ready1),  64'(tbl[i].exp_ready));
      chk($sformatf("v%0d resp_valid", i), 64'(resp_valid1), 64'(tbl[i].exp_rv));
      chk($sformatf("v%0d busy", i),       64'(busy1),       64'(tbl[i].exp_busy));
      if (tbl[i].exp_rv != 4'b0000) begin
        chk($sformatf("v%0d resp_id", i),   64'(resp_id1),   64'(tbl[i].exp_id));
        chk($sformatf("v%0d resp_data", i), 64'(resp_data1), 64'(tbl[i].exp_data));
      end
`ifdef SUB_ARBITER_BORROW_EN
      chk($sformatf("v%0d borrow", i), 64'(resp_borrow1), 64'(tbl[i].exp_brw));
`endif
      @(posedge clk);
      #1;
    end

    // ---------------- reset mid-operation ----------------
    // rr_ptr is 3 here: 3 not valid, 0 not valid, 1 granted
    enable     = 1'b1;
    req_valid1 = 4'b0010;
    #2;
    chk("midrst pre ready", 64'(req_ready1), 64'(4'b0010));
    @(posedge clk);
    #1;
    req_valid1 = 4'b1111;
    reset      = 1'b0;
    #1;
    chk("midrst busy",       64'(busy1),       64'(1'b0));
    chk("midrst resp_valid", 64'(resp_valid1), 64'(4'b0000));
    chk("midrst ready",      64'(req_ready1),  64'(4'b0000));
    @(posedge clk);
    #1;
    reset      = 1'b1;
    req_valid1 = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("midrst after%0d resp_valid", k), 64'(resp_valid1), 64'(4'b0000));
      chk($sformatf("midrst after%0d busy", k),       64'(busy1),       64'(1'b0));
      @(posedge clk);
      #1;
    end
    req_valid1 = 4'b1111;
    #1;
    chk("midrst rr_ptr restart", 64'(req_ready1), 64'(4'b0001));
    @(posedge clk);
    #1;
    req_valid1 = 4'b0000;

    // ---------------- SUB_LAT = 3 back-to-back ----------------
    for (int k = 0; k < 8; k++) begin
      req_valid3 = (k < 3) ? 4'b0111 : 4'b0000;
      #2;
      if (k < 3) begin
        chk($sformatf("lat3 c%0d ready", k), 64'(req_ready3), 64'(4'b0001 << k));
      end
      chk($sformatf("lat3 c%0d resp_valid", k), 64'(resp_valid3), 64'(exp_rv3[k]));
      if (exp_rv3[k] != 4'b0000) begin
        chk($sformatf("lat3 c%0d resp_id", k),   64'(resp_id3),   64'(exp_id3[k]));
        chk($sformatf("lat3 c%0d resp_data", k), 64'(resp_data3), 64'(exp_data3[k]));
      end
      chk($sformatf("lat3 c%0d busy", k), 64'(busy3), 64'((k >= 1) && (k <= 6)));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Shares one registered subtractor datapath (c = a - b, fixed pipeline latency) between NUM_REQ requesters.
- Per-requester valid/ready request handshake; round-robin grant; one issue per cycle.
- Tracks in-flight operations by requester id and routes each result back as a one-cycle response pulse.
- Sits between the requesting units and a single subtractor instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and result width
- SUB_LAT, 1, subtractor latency in cycles from operand presentation to valid result (1..4)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight ops still complete
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; at most one bit set
- req_a  in  NUM_REQ*WIDTH  minuend, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  subtrahend, same packing
- sub_a  out  WIDTH  operand a to subtractor
- sub_b  out  WIDTH  operand b to subtractor
- sub_c  in  WIDTH  subtractor result, valid SUB_LAT cycles after operands
- resp_valid  out  NUM_REQ  one-hot response pulse to the owning requester
- resp_id  out  $clog2(NUM_REQ)  id of the responding requester
- resp_data  out  WIDTH  result, valid when resp_valid != 0
- busy  out  1  any operation in flight

Behaviour:
- Reset (reset=0, asynchronous): rr_ptr=0; tag pipeline cleared; resp_valid=0, resp_id=0, resp_data=0, busy=0.
- Reset also forces req_ready=0 combinationally.
- Tags in flight at reset are discarded; no response is emitted for them.
- Grant (combinational):
  - If enable=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
  - req_ready = onehot(grant); otherwise req_ready=0.
  - Accept = req_valid[i] & req_ready[i].
- Operands: sub_a/sub_b = granted requester's req_a/req_b; hold last accepted values when there is no grant.
- rr_ptr update on accept: (grant+1) mod NUM_REQ. Unchanged without an accept.
- A requester holding valid is granted within NUM_REQ cycles while enable=1.
- Tag pipeline: SUB_LAT-deep shift register of {valid, id}, loaded each cycle with {accept, grant}.
- Response: when the tag pipeline output is valid, register for 1 cycle:
  - resp_valid = onehot(id), resp_id = id, resp_data = sub_c.
  - Total latency is accept-edge + SUB_LAT + 1 cycles.
  - resp_valid deasserts the following cycle unless another tag arrives.
  - Responses cannot be back-pressured; requesters always sink them.
- Throughput: one accept per cycle; back-to-back accepts produce back-to-back responses in issue order.
- busy = OR of tag-pipeline valids OR registered resp_valid.
- Arithmetic: WIDTH-bit modular; a < b wraps (e.g. 3-5 = 0xFFFFFFFE at WIDTH=32). No saturation.
- enable falling with ops in flight: no new grants; outstanding responses still delivered; rr_ptr held.
- Simultaneous requests: exactly one granted per cycle; the others keep valid asserted with ready=0.
- A requester must hold valid and operands stable until accepted.
- Dropping valid before ready is legal; no op is issued for it.

Optional Feature:
- Macro SUB_ARBITER_BORROW_EN.
- Defined:
  - Adds output resp_borrow (1 bit).
  - At accept, borrow = (req_a < req_b) unsigned; carried through the tag pipeline alongside id.
  - Registered with the response; reset value 0; valid only when resp_valid != 0, otherwise 0.
- Not defined: port absent, no borrow logic; all other behaviour identical.

Test Plan:
- Reset, then single op: req_valid[2]=1, a=10, b=3, SUB_LAT=1 -> req_ready=4'b0100 same cycle; two cycles after accept, resp_valid=4'b0100, resp_id=2, resp_data=7, one cycle only; busy falls the cycle after.
- All four requesters valid continuously, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; responses in the same id order, back-to-back, each with its own a-b.
- Wrap: a=3, b=5 -> resp_data=32'hFFFFFFFE; with SUB_ARBITER_BORROW_EN, resp_borrow=1. a=5, b=5 -> resp_data=0, resp_borrow=0.
- enable: drop enable after 2 accepts with requesters still valid -> req_ready=0, both responses still delivered. Re-raise enable -> grant resumes from rr_ptr.
- Reset mid-operation: assert reset=0 one cycle after an accept -> resp_valid stays 0, no response ever emitted for that op; busy=0 immediately.
- SUB_LAT=3: accept 3 ops back-to-back -> responses on cycles accept+4, +5, +6 with the correct ids and data.
